add_sub_datapath: RTL and testbench

ADD_SUB_DATAPATH -- requirements
Module: add_sub_datapath

---
 rtl/add_sub_datapath_if.sv | 28 ++
 rtl/add_sub_datapath.sv | 91 +++++++++
 tb/tb_add_sub_datapath.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/add_sub_datapath_if.sv
// Operand, control and result signals between the sequencing control logic
// (master) and the add/subtract datapath (slave).
interface add_sub_datapath_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] inbus;
  logic             c0;
  logic             c1;
  logic             c3;
  logic             c7;
  logic             res_ack;
  logic [WIDTH-1:0] outbus;
  logic             res_valid;
  logic             carry;
  logic             overflow;
  logic             zero;
  logic             overrun;

  modport master (
    output inbus, c0, c1, c3, c7, res_ack,
    input  outbus, res_valid, carry, overflow, zero, overrun
  );

  modport slave (
    input  inbus, c0, c1, c3, c7, res_ack,
    output outbus, res_valid, carry, overflow, zero, overrun
  );
endinterface

// File: rtl/add_sub_datapath.sv
// M/Q operand registers feeding a shared add/subtract unit; c7 captures the
// result and flags into a held output register with valid/ack and overrun.
module add_sub_datapath #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  add_sub_datapath_if.slave bus
);

  logic [WIDTH-1:0] m_q, m_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             res_valid_q, res_valid_d;
  logic             carry_q, carry_d;
  logic             overflow_q, overflow_d;
  logic             zero_q, zero_d;
  logic             overrun_q, overrun_d;

  logic [WIDTH-1:0] operand_b;
  logic [WIDTH:0]   sum;
  logic             sum_overflow;

  // Subtract is M + ~Q + 1; the +1 enters as the adder's carry-in.
  always_comb begin
    operand_b    = bus.c3 ? ~q_q : q_q;
    sum          = {1'b0, m_q} + {1'b0, operand_b} + {{WIDTH{1'b0}}, bus.c3};
    sum_overflow = (m_q[WIDTH-1] == operand_b[WIDTH-1]) &&
                   (sum[WIDTH-1] != m_q[WIDTH-1]);
  end

  // NOTE: every *_d gets its hold value first so no path leaves it unassigned;
  // that is what keeps this combinational block from inferring latches.
  always_comb begin
    m_d         = m_q;
    q_d         = q_q;
    out_d       = out_q;
    carry_d     = carry_q;
    overflow_d  = overflow_q;
    zero_d      = zero_q;
    res_valid_d = res_valid_q;
    overrun_d   = overrun_q;

    if (bus.c0) m_d = bus.inbus;
    if (bus.c1) q_d = bus.inbus;

    if (bus.c7) begin
      out_d       = sum[WIDTH-1:0];
      carry_d     = sum[WIDTH];
      overflow_d  = sum_overflow;
      zero_d      = (sum[WIDTH-1:0] == '0);
      res_valid_d = 1'b1;
      // A same-edge acknowledge consumes the old result, so nothing is lost.
      if (res_valid_q && !bus.res_ack) overrun_d = 1'b1;
    end else if (bus.res_ack && res_valid_q) begin
      res_valid_d = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of the others, regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      m_q         <= '0;
      q_q         <= '0;
      out_q       <= '0;
      res_valid_q <= 1'b0;
      carry_q     <= 1'b0;
      overflow_q  <= 1'b0;
      zero_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      m_q         <= m_d;
      q_q         <= q_d;
      out_q       <= out_d;
      res_valid_q <= res_valid_d;
      carry_q     <= carry_d;
      overflow_q  <= overflow_d;
      zero_q      <= zero_d;
      overrun_q   <= overrun_d;
    end
  end

  assign bus.outbus    = out_q;
  assign bus.res_valid = res_valid_q;
  assign bus.carry     = carry_q;
  assign bus.overflow  = overflow_q;
  assign bus.zero      = zero_q;
  assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_add_sub_datapath.sv
// Self-checking bench: the driver pushes per-cycle expected outputs from an
// integer-arithmetic model into a scoreboard; a monitor pops and compares.
module tb_add_sub_datapath;
  localparam int WIDTH = 8;

  typedef struct {
    logic [7:0] outbus;
    logic       carry;
    logic       overflow;
    logic       zero;
    logic       res_valid;
    logic       overrun;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb_q[$];

  // Reference model state
  int   m_mdl, q_mdl;
  exp_t mdl;

  add_sub_datapath_if #(.WIDTH(WIDTH)) bus_if ();

  add_sub_datapath #(.WIDTH(WIDTH)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_if)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drives one cycle of inputs, advances the model and queues the outputs
  // expected just after the coming rising edge.
  task automatic step(input logic [7:0] din, input logic ld_m, input logic ld_q,
                      input logic sub, input logic done, input logic ack,
                      input logic rstn = 1'b1);
    int a, b, s, sa, sb, r;
    @(negedge clk);
    rst_n          = rstn;
    bus_if.inbus   = din;
    bus_if.c0      = ld_m;
    bus_if.c1      = ld_q;
    bus_if.c3      = sub;
    bus_if.c7      = done;
    bus_if.res_ack = ack;
    if (!rstn) begin
      m_mdl = 0;
      q_mdl = 0;
      mdl   = '{8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    end else begin
      if (done) begin
        a  = m_mdl;
        b  = q_mdl;
        s  = sub ? a - b : a + b;
        sa = (a >= 128) ? a - 256 : a;
        sb = (b >= 128) ? b - 256 : b;
        r  = sub ? sa - sb : sa + sb;
        mdl.outbus   = 8'(s & 255);
        mdl.carry    = sub ? (a >= b) : (s > 255);
        mdl.overflow = (r > 127) || (r < -128);
        mdl.zero     = ((s & 255) == 0);
        if (mdl.res_valid && !ack) mdl.overrun = 1'b1;
        mdl.res_valid = 1'b1;
      end else if (ack) begin
        mdl.res_valid = 1'b0;
      end
      if (ld_m) m_mdl = din;
      if (ld_q) q_mdl = din;
    end
    sb_q.push_back(mdl);
  endtask

  task automatic compute(input logic [7:0] m, input logic [7:0] q, input logic sub,
                         input logic ack = 1'b0);
    step(m, 1'b1, 1'b0, sub, 1'b0, 1'b0);
    step(q, 1'b0, 1'b1, sub, 1'b0, 1'b0);
    step(8'h00, 1'b0, 1'b0, sub, 1'b1, ack);
  endtask

  // Monitor: compares the DUT outputs one time unit after each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("outbus",    {24'h0, bus_if.outbus},    {24'h0, e.outbus});
        check("carry",     {31'h0, bus_if.carry},     {31'h0, e.carry});
        check("overflow",  {31'h0, bus_if.overflow},  {31'h0, e.overflow});
        check("zero",      {31'h0, bus_if.zero},      {31'h0, e.zero});
        check("res_valid", {31'h0, bus_if.res_valid}, {31'h0, e.res_valid});
        check("overrun",   {31'h0, bus_if.overrun},   {31'h0, e.overrun});
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    bus_if.inbus = '0;
    bus_if.c0 = 1'b0; bus_if.c1 = 1'b0; bus_if.c3 = 1'b0;
    bus_if.c7 = 1'b0; bus_if.res_ack = 1'b0;
    m_mdl = 0; q_mdl = 0;
    mdl = '{8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    step(8'hAA, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Add, subtract, wrap and overflow corners
    compute(8'h35, 8'h12, 1'b0);
    step(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    compute(8'h10, 8'h10, 1'b1, 1'b1);
    compute(8'h00, 8'h01, 1'b1, 1'b1);
    compute(8'h7F, 8'h01, 1'b0, 1'b1);
    compute(8'hFF, 8'h01, 1'b0, 1'b1);
    compute(8'h80, 8'h01, 1'b1, 1'b1);
    step(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);  // ack with nothing held

    // Overrun, then ack clears valid but overrun stays
    compute(8'h03, 8'h04, 1'b0);
    compute(8'h05, 8'h06, 1'b0);
    step(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset, then ack collision must not set overrun
    step(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    compute(8'h20, 8'h01, 1'b0);
    compute(8'h21, 8'h02, 1'b0, 1'b1);
    step(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Same-edge M/Q load with capture uses the old operands
    step(8'h09, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    step(8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);

    // Reset mid-operation with res_valid set and c7 high
    compute(8'h35, 8'h12, 1'b0, 1'b1);
    step(8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    compute(8'h01, 8'h02, 1'b0);

    // c7 held high for several cycles without ack
    for (int i = 0; i < 3; i++) step(8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 500; i++) begin
      step(8'($urandom), ($urandom_range(3) == 0), ($urandom_range(3) == 0),
           1'($urandom), ($urandom_range(2) == 0), ($urandom_range(2) == 0),
           ($urandom_range(39) != 0));
    end

    @(negedge clk);
    @(negedge clk);
    check("scoreboard_drained", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
